pool_out_collector: RTL

//  Downstream stage of the max-pooling unit. Takes the per-cycle sliding-window max stream,

---
 rtl/pool_pkg.sv | 27 ++
 rtl/pool_out_collector_if.sv | 25 ++
 rtl/pool_out_fifo.sv | 52 +++++
 rtl/pool_out_collector.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pooling output path.
// Window sizes are normalised here so every user sees the same 1..4 range.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pool_out_state_t;

    localparam int POOL_WIN_MAX = 4;

    // Only the low 3 bits carry the window size; 0 means a 1-wide window.
    function automatic logic [2:0] win_norm(input logic [15:0] w);
        logic [2:0] v;
        v = w[2:0];
        if (v == 3'd0) begin
            return 3'd1;
        end
        if (v > 3'(POOL_WIN_MAX)) begin
            return 3'(POOL_WIN_MAX);
        end
        return v;
    endfunction

endpackage

// File: rtl/pool_out_collector_if.sv
// Result stream from the pooling collector to the output memory writer.
// Master drives data/address, slave returns ready.
interface pool_out_collector_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;

    modport master (
        output valid,
        output data,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  addr,
        output ready
    );
endinterface

// File: rtl/pool_out_fifo.sv
// Show-ahead synchronous FIFO holding kept {addr, data} pairs.
// A write while full is legal only together with a read of the head.
module pool_out_fifo #(
    parameter int W = 26,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(D);

    logic [PW:0]  wr_ptr_q;
    logic [PW:0]  wr_ptr_d;
    logic [PW:0]  rd_ptr_q;
    logic [PW:0]  rd_ptr_d;
    logic [W-1:0] mem_q [D];
    logic         rd_fire;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        rd_fire  = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q + (PW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (PW+1)'(rd_fire);
        rd_data  = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Head slot is read combinationally before this edge overwrites it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/pool_out_collector.sv
// Keeps the samples that close each non-overlapping pooling window,
// tags them with sequential buffer addresses and queues them for the writer.
module pool_out_collector
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10,
    parameter int FIFO_D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     row_length,
    input  logic [CNT_W-1:0]     num_rows,
    input  logic [15:0]          pool_horiz,
    input  logic [15:0]          pool_vert,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    pool_out_collector_if.master out_if,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    pool_out_state_t state_q;
    pool_out_state_t state_d;

    logic [CNT_W-1:0]  rl_q;
    logic [CNT_W-1:0]  rl_d;
    logic [CNT_W-1:0]  nr_q;
    logic [CNT_W-1:0]  nr_d;
    logic [2:0]        h_q;
    logic [2:0]        h_d;
    logic [2:0]        v_q;
    logic [2:0]        v_d;
    logic [CNT_W-1:0]  col_q;
    logic [CNT_W-1:0]  col_d;
    logic [CNT_W-1:0]  row_q;
    logic [CNT_W-1:0]  row_d;
    logic [1:0]        col_ph_q;
    logic [1:0]        col_ph_d;
    logic [1:0]        row_ph_q;
    logic [1:0]        row_ph_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              ovf_q;
    logic              ovf_d;

    logic col_last_ph;
    logic row_last_ph;
    logic keep;
    logic pop;
    logic fifo_wr;
    logic fifo_full;
    logic fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_rd;

    always_comb begin
        col_last_ph = ({1'b0, col_ph_q} == (h_q - 3'd1));
        row_last_ph = ({1'b0, row_ph_q} == (v_q - 3'd1));
        keep        = (state_q == RUN) & in_valid &
                      col_last_ph & row_last_ph;
        pop         = out_if.valid & out_if.ready;
        // A full FIFO still accepts when its head leaves the same cycle.
        fifo_wr     = keep & (~fifo_full | pop);
    end

    always_comb begin
        state_d  = state_q;
        rl_d     = rl_q;
        nr_d     = nr_q;
        h_d      = h_q;
        v_d      = v_q;
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    rl_d     = row_length;
                    nr_d     = num_rows;
                    h_d      = win_norm(pool_horiz);
                    v_d      = win_norm(pool_vert);
                    col_d    = '0;
                    row_d    = '0;
                    col_ph_d = '0;
                    row_ph_d = '0;
                    addr_d   = base_addr;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (keep) begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (fifo_full & ~pop) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (col_q == rl_q - CNT_W'(1)) begin
                        col_d    = '0;
                        col_ph_d = '0;
                        row_d    = row_q + CNT_W'(1);
                        row_ph_d = row_last_ph ? 2'd0 : row_ph_q + 2'd1;
                        if (row_q == nr_q - CNT_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d    = col_q + CNT_W'(1);
                        col_ph_d = col_last_ph ? 2'd0 : col_ph_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rl_q     <= '0;
            nr_q     <= '0;
            h_q      <= 3'd1;
            v_q      <= 3'd1;
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rl_q     <= rl_d;
            nr_q     <= nr_d;
            h_q      <= h_d;
            v_q      <= v_d;
            col_q    <= col_d;
            row_q    <= row_d;
            col_ph_q <= col_ph_d;
            row_ph_q <= row_ph_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
        end
    end

    pool_out_fifo #(
        .W (ADDR_W + DATA_W),
        .D (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({addr_q, in_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_if.valid = ~fifo_empty;
    assign out_if.addr  = fifo_rd[ADDR_W+DATA_W-1:DATA_W];
    assign out_if.data  = fifo_rd[DATA_W-1:0];

    assign busy     = (state_q == RUN) | (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

endmodule
